reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Arbitrates NUM_REQ E-tile register-access requesters (tile side of reg_access_if) onto one R-tile bank port (bank side of reg_access_if).
- Round-robin grant; one transaction outstanding at a time.
- Checks G-register bank alignment locally (reg_id mod 4 must equal BANK_ID); misaligned requests are rejected without touching the bank.
- Returns read data, ack and alignment error to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, width of reg_data_t.
- BANK_ID, 0, bank index 0..3, compared with reg_id[1:0].
- TIMEOUT, 64, bank-ack watchdog limit in cycles; used only with REG_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_read_req  in  NUM_REQ  per-requester read request (level).
- req_write_req  in  NUM_REQ  per-requester write request (level).
- req_reg_id  in  NUM_REQ*7  packed G[0-127] ids; requester i occupies [7i+6:7i].
- req_queue_id  in  NUM_REQ*5  packed R/W queue ids.
- req_write_data  in  NUM_REQ*DATA_W  packed write data.
- req_read_data  out  DATA_W  shared read data; valid only with a req_ack bit.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_alignment_err  out  NUM_REQ  error qualifier; valid only with req_ack.
- bank_read_req  out  1  to R-tile bank.
- bank_write_req  out  1  to R-tile bank.
- bank_reg_id  out  7  to R-tile bank.
- bank_queue_id  out  5  to R-tile bank.
- bank_write_data  out  DATA_W  to R-tile bank.
- bank_read_data  in  DATA_W  from R-tile bank.
- bank_ack  in  1  from R-tile bank.
- bank_alignment_err  in  1  from R-tile bank.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; mask=0.
- Requester protocol: requester i raises read_req or write_req and holds reg_id, queue_id and write_data stable until it sees req_ack[i]. It deasserts its request no later than the cycle after the ack.
- Both read and write asserted by one requester is illegal. The block services it as a write only and acks once.
- FSM:
  - IDLE: eligible = (read_req | write_req) & ~mask. Pick the first eligible index searching upward from rr_ptr with wrap, latch it into grant_id, and clear mask.
    - If the winner's reg_id[1:0] != BANK_ID: go to RESP with err=1 and no bank access.
    - Otherwise latch its fields into the bank_* registers and go to ISSUE.
    - No eligible requester: stay in IDLE.
  - ISSUE: bank_read_req or bank_write_req is high (registered) and bank fields are stable. If bank_ack is high, capture bank_read_data and bank_alignment_err and go to RESP; otherwise go to WAIT.
  - WAIT: bank request stays held. On bank_ack, capture data and err, drop the bank request, and go to RESP.
  - RESP: req_ack[grant_id]=1 for exactly one cycle. req_alignment_err[grant_id]=err. req_read_data=captured data (0 for writes and for errors). Set rr_ptr=grant_id+1 mod NUM_REQ, set mask=onehot(grant_id), and go to IDLE.
- mask blocks re-grant of the just-served requester for its first IDLE cycle only.
- Latency:
  - Misaligned request: ack 2 cycles after the request is sampled in IDLE.
  - Aligned request with bank_ack in ISSUE: ack 3 cycles after sampling.
  - Each extra bank wait cycle adds 1.
- Bank requests drop the cycle after bank_ack is seen; the bank never sees back-to-back requests without an intervening IDLE cycle.
- Requests arriving while busy stay pending and are not lost.
- rst mid-transaction: the FSM aborts to IDLE, and bank_* and req_ack are cleared immediately (asynchronously). No ack is issued for the aborted transaction.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT. When the counter reaches TIMEOUT-1 with no bank_ack, the block drops the bank request, goes to RESP with err=1 and data 0, and sets a sticky output timeout_seen (1-bit, cleared only by rst).
- Not defined: no counter and no timeout_seen port; WAIT is held indefinitely.

Test Plan:
- Single read: requester 1 reads reg_id=0x04 (BANK_ID=0); bank acks in ISSUE with data 0xDEAD -> req_ack[1] 3 cycles after request, read_data=0xDEAD, err=0, grant_id=1.
- Misaligned: requester 0 writes reg_id=0x05 -> bank_*_req never asserted, req_ack[0] with req_alignment_err[0]=1 after 2 cycles.
- Round-robin: all 4 requesters hold requests continuously from reset -> grant order 0,1,2,3,0; no requester is granted twice in a row.
- Bank stall: bank_ack delayed 5 cycles -> bank_write_req and fields held stable for 6 cycles; one ack pulse; req_read_data=0.
- Reset mid-WAIT: assert rst while in WAIT -> bank_read_req goes to 0 immediately; no req_ack; after release, a held request is re-granted from rr_ptr=0.
- With REG_ARB_TIMEOUT_EN and TIMEOUT=8: bank never acks -> err ack after 8 bank-request cycles; timeout_seen=1 stays sticky.

Source files
------------

// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - register-access bundle of N request lanes (tile side N=NUM_REQ, bank side N=1)
interface reg_bank_arbiter_if #(
  parameter int N      = 1,
  parameter int DATA_W = 64
);
  logic [N-1:0]        read_req;
  logic [N-1:0]        write_req;
  logic [N*7-1:0]      reg_id;
  logic [N*5-1:0]      queue_id;
  logic [N*DATA_W-1:0] write_data;
  logic [DATA_W-1:0]   read_data;
  logic [N-1:0]        ack;
  logic [N-1:0]        alignment_err;

  modport master (
    output read_req, write_req, reg_id, queue_id, write_data,
    input  read_data, ack, alignment_err
  );

  modport slave (
    input  read_req, write_req, reg_id, queue_id, write_data,
    output read_data, ack, alignment_err
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbiter of NUM_REQ register requesters onto one bank port
// Optional bank-ack watchdog and sticky timeout_seen output under REG_ARB_TIMEOUT_EN.
module reg_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int BANK_ID = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  reg_bank_arbiter_if.slave          req,
  reg_bank_arbiter_if.master         bank,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef REG_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_seen
`endif
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]  mask;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                found;
  logic [PW-1:0]       winner;
  logic                aligned;
  logic                err_q;
  logic [DATA_W-1:0]   data_q;
  logic                tmo_hit;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || BANK_ID < 0 || BANK_ID > 3) begin : g_bad_cfg
    $error("reg_bank_arbiter: parameter out of range");
  end

  // First eligible requester at or above rr_ptr, wrapping around.
  always_comb begin
    eligible = (req.read_req | req.write_req) & ~mask;
    found    = 1'b0;
    winner   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign aligned  = (req.reg_id[7*winner +: 2] == 2'(BANK_ID));
  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = ((state == ISSUE) || (state == WAIT)) && !bank.ack[0] &&
                   (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt      <= '0;
      timeout_seen <= 1'b0;
    end else begin
      if (state_nxt == ISSUE)
        tmo_cnt <= '0;
      else if ((state == ISSUE) || (state == WAIT))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        timeout_seen <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (found) state_nxt = aligned ? ISSUE : RESP;
      ISSUE, WAIT: state_nxt = (bank.ack[0] || tmo_hit) ? RESP : WAIT;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      mask            <= '0;
      grant_id        <= '0;
      err_q           <= 1'b0;
      data_q          <= '0;
      bank.read_req   <= '0;
      bank.write_req  <= '0;
      bank.reg_id     <= '0;
      bank.queue_id   <= '0;
      bank.write_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          mask <= '0;
          if (found) begin
            grant_id <= winner;
            data_q   <= '0;
            err_q    <= !aligned;
            if (aligned) begin
              // A requester raising both strobes is serviced as a write.
              bank.write_req  <= req.write_req[winner];
              bank.read_req   <= !req.write_req[winner];
              bank.reg_id     <= req.reg_id[7*winner +: 7];
              bank.queue_id   <= req.queue_id[5*winner +: 5];
              bank.write_data <= req.write_data[DATA_W*winner +: DATA_W];
            end
          end
        end
        ISSUE, WAIT: begin
          if (bank.ack[0]) begin
            bank.read_req  <= '0;
            bank.write_req <= '0;
            err_q          <= bank.alignment_err[0];
            data_q         <= (bank.read_req[0] && !bank.alignment_err[0]) ? bank.read_data : '0;
          end else if (tmo_hit) begin
            bank.read_req  <= '0;
            bank.write_req <= '0;
            err_q          <= 1'b1;
            data_q         <= '0;
          end
        end
        RESP: begin
          rr_ptr <= (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          mask   <= grant_oh;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy              = (state != IDLE);
    req.ack           = (state == RESP) ? grant_oh : '0;
    req.alignment_err = (state == RESP && err_q) ? grant_oh : '0;
    req.read_data     = (state == RESP) ? data_q : '0;
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed self-checking bench for reg_bank_arbiter (4 requesters, BANK_ID 0, TIMEOUT 8)
module tb_reg_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] grant_id;
`ifdef REG_ARB_TIMEOUT_EN
  logic       timeout_seen;
`endif

  reg_bank_arbiter_if #(.N(4), .DATA_W(64)) req_if ();
  reg_bank_arbiter_if #(.N(1), .DATA_W(64)) bank_if ();

  reg_bank_arbiter #(.NUM_REQ(4), .DATA_W(64), .BANK_ID(0), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if),
    .bank         (bank_if),
    .busy         (busy),
    .grant_id     (grant_id)
`ifdef REG_ARB_TIMEOUT_EN
    ,
    .timeout_seen (timeout_seen)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // bank model knobs and monitor results
  int          bank_delay   = 0;
  bit          bank_never   = 0;
  bit          bank_err_val = 0;
  logic [63:0] bank_rdata   = '0;
  int          hold_cnt     = 0;
  int          last_hold    = 0;
  int          bank_req_seen = 0;
  int          field_changes = 0;
  logic [6:0]  mon_reg_id;
  logic [4:0]  mon_qid;
  logic [63:0] mon_wdata;
  logic        mon_read, mon_write;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank responder: acks on the (bank_delay+1)-th cycle of a held request.
  initial begin
    bank_if.ack           = '0;
    bank_if.alignment_err = '0;
    bank_if.read_data     = '0;
    forever begin
      @(negedge clk);
      if (bank_if.read_req[0] || bank_if.write_req[0]) begin
        if (hold_cnt == 0) begin
          bank_req_seen++;
          mon_reg_id = bank_if.reg_id;
          mon_qid    = bank_if.queue_id;
          mon_wdata  = bank_if.write_data;
          mon_read   = bank_if.read_req[0];
          mon_write  = bank_if.write_req[0];
        end else if (mon_reg_id !== bank_if.reg_id || mon_qid !== bank_if.queue_id ||
                     mon_wdata !== bank_if.write_data || mon_read !== bank_if.read_req[0] ||
                     mon_write !== bank_if.write_req[0]) begin
          field_changes++;
        end
        hold_cnt++;
        if (!bank_never && hold_cnt == bank_delay + 1) begin
          bank_if.ack[0]           = 1'b1;
          bank_if.read_data        = bank_rdata;
          bank_if.alignment_err[0] = bank_err_val;
        end else begin
          bank_if.ack           = '0;
          bank_if.read_data     = '0;
          bank_if.alignment_err = '0;
        end
      end else begin
        if (hold_cnt != 0) last_hold = hold_cnt;
        hold_cnt              = 0;
        bank_if.ack           = '0;
        bank_if.read_data     = '0;
        bank_if.alignment_err = '0;
      end
    end
  end

  task automatic set_req(input int idx, input bit rd, input bit wr, input logic [6:0] rid,
                         input logic [4:0] qid, input logic [63:0] wd);
    req_if.read_req[idx]             = rd;
    req_if.write_req[idx]            = wr;
    req_if.reg_id[7*idx +: 7]        = rid;
    req_if.queue_id[5*idx +: 5]      = qid;
    req_if.write_data[64*idx +: 64]  = wd;
  endtask

  // Cycle 1 is the cycle the request is first presented; returns the cycle in which ack shows.
  task automatic wait_ack(output int cyc, output bit got);
    cyc = 1;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_if.ack != 0) got = 1;
    end
  endtask

  task automatic run_txn(input string tag, input int idx, input bit rd, input bit wr,
                         input logic [6:0] rid, input logic [4:0] qid, input logic [63:0] wd,
                         input int exp_lat, input bit exp_err, input logic [63:0] exp_data);
    int cyc;
    bit got;
    @(negedge clk);
    set_req(idx, rd, wr, rid, qid, wd);
    wait_ack(cyc, got);
    check({tag, "_latency"}, got ? 64'(cyc) : 64'd0, 64'(exp_lat));
    check({tag, "_ack"}, 64'(req_if.ack), 64'(4'b0001 << idx));
    check({tag, "_err"}, 64'(req_if.alignment_err), exp_err ? 64'(4'b0001 << idx) : 64'd0);
    check({tag, "_data"}, req_if.read_data, exp_data);
    check({tag, "_grant"}, 64'(grant_id), 64'(idx));
    set_req(idx, 0, 0, rid, qid, wd);
    @(negedge clk);
    check({tag, "_single_ack"}, 64'(req_if.ack), 64'd0);
    @(negedge clk);
  endtask

  int          acks;
  int          order [5];
  int          cyc;
  bit          got;
  int          seen_before;
  int          ack_during;

  initial begin
    req_if.read_req   = '0;
    req_if.write_req  = '0;
    req_if.reg_id     = '0;
    req_if.queue_id   = '0;
    req_if.write_data = '0;

    // reset state, with all four requesters already waiting
    @(negedge clk);
    set_req(0, 1, 0, 7'h00, 5'd0, 64'd0);
    set_req(1, 1, 0, 7'h04, 5'd1, 64'd0);
    set_req(2, 1, 0, 7'h08, 5'd2, 64'd0);
    set_req(3, 1, 0, 7'h0C, 5'd3, 64'd0);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_grant", 64'(grant_id), 64'd0);
    check("reset_ack", 64'(req_if.ack), 64'd0);
    check("reset_bank_rd", 64'(bank_if.read_req), 64'd0);
    check("reset_bank_wr", 64'(bank_if.write_req), 64'd0);
    check("reset_rdata", req_if.read_data, 64'd0);
`ifdef REG_ARB_TIMEOUT_EN
    check("reset_timeout_seen", 64'(timeout_seen), 64'd0);
`endif

    // round robin with requests held continuously
    rst  = 1'b0;
    acks = 0;
    for (int n = 0; n < 80 && acks < 5; n++) begin
      @(negedge clk);
      if (req_if.ack != 0) begin
        order[acks] = int'(grant_id);
        acks++;
      end
    end
    check("rr_acks", 64'(acks), 64'd5);
    check("rr_0", 64'(order[0]), 64'd0);
    check("rr_1", 64'(order[1]), 64'd1);
    check("rr_2", 64'(order[2]), 64'd2);
    check("rr_3", 64'(order[3]), 64'd3);
    check("rr_4", 64'(order[4]), 64'd0);
    req_if.read_req = '0;
    repeat (3) @(negedge clk);

    // single aligned read, bank acks in ISSUE
    bank_rdata = 64'hDEAD;
    run_txn("read", 1, 1, 0, 7'h04, 5'd9, 64'd0, 3, 0, 64'hDEAD);
    check("read_bank_regid", 64'(mon_reg_id), 64'h04);
    check("read_bank_qid", 64'(mon_qid), 64'd9);

    // misaligned write never reaches the bank
    seen_before = bank_req_seen;
    run_txn("misalign", 0, 0, 1, 7'h05, 5'd2, 64'h1111, 2, 1, 64'd0);
    check("misalign_no_bank", 64'(bank_req_seen), 64'(seen_before));

    // bank reports an alignment error: error forwarded, data suppressed
    bank_err_val = 1;
    bank_rdata   = 64'h1234;
    run_txn("bank_err", 0, 1, 0, 7'h00, 5'd3, 64'd0, 3, 1, 64'd0);
    bank_err_val = 0;

    // read and write both raised: serviced as one write
    run_txn("rw_both", 3, 1, 1, 7'h0C, 5'd4, 64'hCAFE, 3, 0, 64'd0);
    check("rw_both_is_write", 64'(mon_write), 64'd1);
    check("rw_both_not_read", 64'(mon_read), 64'd0);
    check("rw_both_wdata", mon_wdata, 64'hCAFE);

    // bank stall of 5 cycles
    bank_delay    = 5;
    field_changes = 0;
    run_txn("stall", 2, 0, 1, 7'h08, 5'h1F, 64'h55AA, 8, 0, 64'd0);
    check("stall_hold", 64'(last_hold), 64'd6);
    check("stall_stable", 64'(field_changes), 64'd0);
    check("stall_wdata", mon_wdata, 64'h55AA);
    bank_delay = 0;

    // reset while in WAIT; rr_ptr is 3 here, so the re-grant of 1 over 3 shows it went back to 0
    bank_never = 1;
    ack_during = 0;
    @(negedge clk);
    set_req(1, 1, 0, 7'h04, 5'd1, 64'd0);
    repeat (4) begin
      @(negedge clk);
      if (req_if.ack != 0) ack_during++;
    end
    check("abort_in_wait", 64'(bank_if.read_req), 64'd1);
    rst = 1'b1;
    set_req(3, 1, 0, 7'h0C, 5'd3, 64'd0);
    #1;
    check("abort_bank_rd", 64'(bank_if.read_req), 64'd0);
    check("abort_ack", 64'(req_if.ack), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_no_ack_before", 64'(ack_during), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    bank_never = 0;
    wait_ack(cyc, got);
    check("regrant_got", 64'(got), 64'd1);
    check("regrant_ack", 64'(req_if.ack), 64'b0010);
    check("regrant_grant", 64'(grant_id), 64'd1);
    req_if.read_req[1] = 1'b0;
    wait_ack(cyc, got);
    check("regrant_next", 64'(req_if.ack), 64'b1000);
    req_if.read_req[3] = 1'b0;
    repeat (2) @(negedge clk);

`ifdef REG_ARB_TIMEOUT_EN
    // watchdog: bank never acks, TIMEOUT=8
    bank_never = 1;
    run_txn("timeout", 0, 1, 0, 7'h00, 5'd0, 64'd0, 10, 1, 64'd0);
    check("timeout_hold", 64'(last_hold), 64'd8);
    check("timeout_seen", 64'(timeout_seen), 64'd1);
    bank_never = 0;
    bank_rdata = 64'h77;
    run_txn("after_timeout", 1, 1, 0, 7'h04, 5'd0, 64'd0, 3, 0, 64'h77);
    check("timeout_sticky", 64'(timeout_seen), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
